// File: rtl/musica_pkg.sv
// Shared types for the note sequencer path.
// Mode codes and sequencer state encodings.
package musica_pkg;

  localparam logic [1:0] MODE_LOOP     = 2'b00;
  localparam logic [1:0] MODE_ONESHOT  = 2'b01;
  localparam logic [1:0] MODE_PINGPONG = 2'b10;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_DONE = 1'b1
  } state_t;

endpackage

// File: rtl/divisor_tick.sv
// Clock-enable prescaler for the note sequencer.
// Emits a one-cycle tick every TICK_DIV enabled cycles.
module divisor_tick #(
  parameter int TICK_DIV = 12_500_000,
  parameter int DIV_W    = 24
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam logic [DIV_W-1:0] CNT_TOP = DIV_W'(TICK_DIV - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;
  logic             at_top;

  assign at_top = (cnt_q == CNT_TOP);
  assign tick   = en & ~clr & at_top;

  // Next count: clear wins, then wrap at the top, else advance when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = at_top ? '0 : cnt_q + DIV_W'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/secuenciador_pasos.sv
// Note-index sequencer: loop, one-shot and ping-pong
// walks over 0..last_idx at the prescaled step rate.
module secuenciador_pasos
  import musica_pkg::*;
#(
  parameter int ADDR_W   = 8,
  parameter int TICK_DIV = 12_500_000,
  parameter int DIV_W    = 24
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pause,
  input  logic              restart,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] last_idx,
  output logic [ADDR_W-1:0] idx,
  output logic              step,
  output logic              wrap,
  output logic              done,
  output logic              busy
);

  localparam logic [ADDR_W-1:0] ONE = ADDR_W'(1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              dir_dn_q, dir_dn_d;
  logic              step_q, step_d;
  logic              wrap_q, wrap_d;
  logic              done_q, done_d;
  logic              busy_q, busy_d;
  logic              step_en;

  divisor_tick #(
    .TICK_DIV (TICK_DIV),
    .DIV_W    (DIV_W)
  ) u_div (
    .clk   (clk),
    .rst_n (rst_n),
    .en    ((state_q == ST_RUN) & ~pause),
    .clr   (restart),
    .tick  (step_en)
  );

  // Next index/direction/state; strobes default low every cycle.
  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    dir_dn_d = dir_dn_q;
    done_d   = done_q;
    busy_d   = busy_q;
    step_d   = 1'b0;
    wrap_d   = 1'b0;
    if (restart) begin
      state_d  = ST_RUN;
      idx_d    = '0;
      dir_dn_d = 1'b0;
      done_d   = 1'b0;
      busy_d   = 1'b1;
    end else if (state_q == ST_RUN && step_en) begin
      if (idx_q > last_idx) begin
        idx_d    = '0;
        dir_dn_d = 1'b0;
        if (mode == MODE_ONESHOT) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
          busy_d  = 1'b0;
        end else begin
          step_d = 1'b1;
          wrap_d = 1'b1;
        end
      end else begin
        case (mode)
          MODE_ONESHOT: begin
            dir_dn_d = 1'b0;
            if (idx_q < last_idx) begin
              idx_d  = idx_q + ONE;
              step_d = 1'b1;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              busy_d  = 1'b0;
            end
          end
          MODE_PINGPONG: begin
            step_d = 1'b1;
            if (!dir_dn_q) begin
              if (idx_q < last_idx) begin
                idx_d = idx_q + ONE;
              end else if (last_idx == '0) begin
                idx_d  = '0;
                wrap_d = 1'b1;
              end else begin
                dir_dn_d = 1'b1;
                idx_d    = idx_q - ONE;
              end
            end else if (idx_q > ONE) begin
              idx_d = idx_q - ONE;
            end else begin
              idx_d    = '0;
              dir_dn_d = 1'b0;
              wrap_d   = 1'b1;
            end
          end
          default: begin
            dir_dn_d = 1'b0;
            step_d   = 1'b1;
            if (idx_q < last_idx) begin
              idx_d = idx_q + ONE;
            end else begin
              idx_d  = '0;
              wrap_d = 1'b1;
            end
          end
        endcase
      end
    end
  end

  // Sequencer registers; outputs come straight from flops.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_RUN;
      idx_q    <= '0;
      dir_dn_q <= 1'b0;
      step_q   <= 1'b0;
      wrap_q   <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b1;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      dir_dn_q <= dir_dn_d;
      step_q   <= step_d;
      wrap_q   <= wrap_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
    end
  end

  assign idx  = idx_q;
  assign step = step_q;
  assign wrap = wrap_q;
  assign done = done_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_secuenciador_pasos.sv
// Directed bench for secuenciador_pasos with TICK_DIV=4.
// Checks step timing, modes, pause, restart and async reset.
module tb_secuenciador_pasos;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pause = 1'b0;
  logic       restart = 1'b0;
  logic [1:0] mode = 2'b00;
  logic [7:0] last_idx = 8'd3;
  logic [7:0] idx;
  logic       step;
  logic       wrap;
  logic       done;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  secuenciador_pasos #(
    .ADDR_W   (8),
    .TICK_DIV (4),
    .DIV_W    (24)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .pause    (pause),
    .restart  (restart),
    .mode     (mode),
    .last_idx (last_idx),
    .idx      (idx),
    .step     (step),
    .wrap     (wrap),
    .done     (done),
    .busy     (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Three quiet cycles, then a step with the given idx/wrap.
  task automatic expect_step(input string tag, input logic [7:0] ei,
                             input logic ew);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk({tag, "_quiet"}, 32'(step), 32'd0);
    end
    cyc();
    chk({tag, "_step"}, 32'(step), 32'd1);
    chk({tag, "_idx"}, 32'(idx), 32'(ei));
    chk({tag, "_wrap"}, 32'(wrap), 32'(ew));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_idx"}, 32'(idx), 32'd0);
    chk({tag, "_step"}, 32'(step), 32'd0);
    chk({tag, "_wrap"}, 32'(wrap), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
  endtask

  initial begin
    // 1: loop, last_idx=3
    repeat (2) cyc();
    chk_reset("rst");
    rst_n = 1'b1;
    expect_step("loop1", 8'd1, 1'b0);
    expect_step("loop2", 8'd2, 1'b0);
    expect_step("loop3", 8'd3, 1'b0);
    expect_step("loop0", 8'd0, 1'b1);

    // 2: one-shot, last_idx=2
    mode = 2'b01;
    last_idx = 8'd2;
    expect_step("os1", 8'd1, 1'b0);
    expect_step("os2", 8'd2, 1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc();
      chk("os_end_step", 32'(step), 32'd0);
    end
    chk("os_done", 32'(done), 32'd1);
    chk("os_busy", 32'(busy), 32'd0);
    chk("os_idx", 32'(idx), 32'd2);
    for (int i = 0; i < 8; i++) begin
      cyc();
      chk("os_hold_step", 32'(step), 32'd0);
    end
    chk("os_hold_idx", 32'(idx), 32'd2);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk_reset("os_rs");

    // 3: ping-pong, last_idx=3
    mode = 2'b10;
    last_idx = 8'd3;
    expect_step("pp1", 8'd1, 1'b0);
    expect_step("pp2", 8'd2, 1'b0);
    expect_step("pp3", 8'd3, 1'b0);
    expect_step("pp2d", 8'd2, 1'b0);
    expect_step("pp1d", 8'd1, 1'b0);
    expect_step("pp0", 8'd0, 1'b1);
    expect_step("pp1u", 8'd1, 1'b0);
    last_idx = 8'd0;
    expect_step("pp_l0a", 8'd0, 1'b1);
    expect_step("pp_l0b", 8'd0, 1'b1);

    // 4: pause 2 clks into an interval, held 10 clks
    mode = 2'b00;
    last_idx = 8'd3;
    repeat (2) cyc();
    pause = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc();
      chk("pz_step", 32'(step), 32'd0);
    end
    chk("pz_idx", 32'(idx), 32'd0);
    pause = 1'b0;
    cyc();
    chk("pz_rel1", 32'(step), 32'd0);
    cyc();
    chk("pz_rel2", 32'(step), 32'd1);
    chk("pz_idx2", 32'(idx), 32'd1);

    // 5: restart on the step_en cycle
    repeat (3) cyc();
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("rs_idx", 32'(idx), 32'd0);
    chk("rs_step", 32'(step), 32'd0);
    chk("rs_wrap", 32'(wrap), 32'd0);
    expect_step("rs_next", 8'd1, 1'b0);
    repeat (2) cyc();
    #2;
    rst_n = 1'b0;
    #1;
    chk_reset("arst");
    @(negedge clk);
    rst_n = 1'b1;

    // 6: loop, last_idx shrinks 5->1 at idx=3
    last_idx = 8'd5;
    expect_step("sh1", 8'd1, 1'b0);
    expect_step("sh2", 8'd2, 1'b0);
    expect_step("sh3", 8'd3, 1'b0);
    last_idx = 8'd1;
    expect_step("sh0", 8'd0, 1'b1);
    expect_step("sh1b", 8'd1, 1'b0);
    expect_step("sh0b", 8'd0, 1'b1);
    expect_step("sh1c", 8'd1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
